bip_program_loader: RTL and testbench
=====================================

Name: bip_program_loader

Overview:
- Responder side of the BIP instruction-fetch interface: owns the instruction memory and answers the control unit's fetch address with an instruction word.
- Before execution it loads a program from a byte stream (UART RX side), high byte first. It holds the CPU in reset and invalid during the load.
- On load completion it releases the CPU and serves fetches combinationally. This gives zero-latency reads, so the PC and the instruction it selects stay aligned in the same cycle.

Parameters:
- NB_DATA, 16, instruction word width
- NB_OPCODE, 5, opcode field width (instruction MSBs)
- NB_BYTE, 8, input byte width
- N_INSMEM_ADDR, 2048, instruction memory depth in words
- LOG2_N_INSMEM_ADDR, 11, fetch/write address width

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse: begin (re)loading a program
- i_byte  in  NB_BYTE  program byte
- i_byte_valid  in  1  i_byte valid this cycle
- i_addr_instr  in  LOG2_N_INSMEM_ADDR  fetch address from control (PC)
- o_instruction  out  NB_DATA  fetched instruction
- o_cpu_valid  out  1  CPU enable, drives control i_valid
- o_cpu_reset  out  1  active-high synchronous reset to CPU
- o_loading  out  1  load in progress
- o_done  out  1  program loaded, CPU running
- o_overflow  out  1  sticky: memory filled without a HALT word
- o_word_count  out  LOG2_N_INSMEM_ADDR+1  words written in current load

Behaviour:
- Reset (i_reset=0, asynchronous) puts the block in IDLE with all internal registers cleared.
  - Output values in reset: o_cpu_valid=0, o_cpu_reset=1, o_loading=0, o_done=0, o_overflow=0, o_word_count=0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD_HI, LOAD_LO, RUN.
- IDLE:
  - i_start -> LOAD_HI; clear write pointer, o_word_count and o_overflow.
  - Bytes arriving in IDLE are ignored.
- LOAD_HI:
  - On i_byte_valid, latch i_byte as bits [15:8] -> LOAD_LO.
- LOAD_LO:
  - On i_byte_valid, write {hi, i_byte} to mem[wr_ptr] at the clock edge.
  - Increment wr_ptr and o_word_count.
  - Next state:
    - Word opcode (bits [15:11]) == 0 (HALT) -> RUN.
    - Else, wr_ptr was N_INSMEM_ADDR-1 -> RUN and set o_overflow=1. wr_ptr does not wrap; no further writes.
    - Else -> LOAD_HI.
- RUN:
  - o_cpu_valid=1, o_cpu_reset=0, o_done=1.
  - i_start -> LOAD_HI, same clears as from IDLE. The old program is overwritten in place.
- Output decode per state:
  - o_loading=1 in LOAD_HI and LOAD_LO.
  - o_cpu_reset=1 in every state except RUN.
  - o_cpu_valid and o_done are 1 only in RUN.
- Fetch path (combinational, zero latency):
  - o_instruction = mem[i_addr_instr] in RUN; 16'h0000 (HALT) in all other states.
  - Out-of-range addresses cannot occur: the address width exactly covers the memory.
- Simultaneous i_start and i_byte_valid:
  - i_start wins; the byte is dropped.
  - In LOAD_HI/LOAD_LO, i_start restarts the load (wr_ptr=0, any partial word discarded).
- Gaps between bytes are unbounded; there is no timeout. The state holds while i_byte_valid=0.
- Reset mid-load returns to IDLE immediately. A partially loaded program is not executable: IDLE serves HALT.
- Write-then-read in the same cycle does not occur, because reads are only served in RUN.

Test Plan:
- Reset then i_start; stream 8'h18,8'h05, 8'h00,8'h00 -> mem[0]=16'h1805, mem[1]=16'h0000.
  - Then RUN: o_word_count=2, o_cpu_reset=0, o_cpu_valid=1.
  - i_addr_instr=0 -> o_instruction=16'h1805 in the same cycle.
- Bytes with 3-cycle idle gaps, including a gap between hi and lo -> identical memory contents and word count to the back-to-back case.
- Stream 2048 words with no HALT opcode -> RUN after the 2048th word, o_overflow=1, o_word_count=2048.
  - An extra 2049th byte pair is ignored and mem[0] is unchanged.
- i_start asserted in LOAD_LO after hi byte 8'h10 -> partial word discarded.
  - Next bytes 8'h00,8'h00 land at mem[0]; o_word_count=1.
- In RUN, pulse i_start -> next cycle o_cpu_valid=0, o_cpu_reset=1, o_instruction=16'h0000 for any address, o_done=0.
- Drive i_reset=0 asynchronously between clock edges while in LOAD_LO -> outputs reach their reset values without waiting for an edge.
  - After i_reset=1, a byte with no preceding i_start is ignored.

Source files
------------

// File: rtl/bip_program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : bip_program_loader_if
// Description : Bundle between the BIP program loader and its surroundings.
//               Carries the byte-stream input (program upload), the fetch
//               path to the control unit (PC in, instruction out) and the
//               CPU enable/reset and load status outputs.
//               slave  : the loader (consumes bytes/PC, drives instruction)
//               master : the environment (UART RX + control unit + monitor)
// Revision    : 1.0 - initial release
// ============================================================================
interface bip_program_loader_if #(
  parameter int NB_DATA            = 16,
  parameter int NB_BYTE            = 8,
  parameter int LOG2_N_INSMEM_ADDR = 11
);

  // Load control and byte stream
  logic                          i_start;
  logic [NB_BYTE-1:0]            i_byte;
  logic                          i_byte_valid;

  // Fetch path
  logic [LOG2_N_INSMEM_ADDR-1:0] i_addr_instr;
  logic [NB_DATA-1:0]            o_instruction;

  // CPU control and load status
  logic                          o_cpu_valid;
  logic                          o_cpu_reset;
  logic                          o_loading;
  logic                          o_done;
  logic                          o_overflow;
  logic [LOG2_N_INSMEM_ADDR:0]   o_word_count;

  modport slave (
    input  i_start,
    input  i_byte,
    input  i_byte_valid,
    input  i_addr_instr,
    output o_instruction,
    output o_cpu_valid,
    output o_cpu_reset,
    output o_loading,
    output o_done,
    output o_overflow,
    output o_word_count
  );

  modport master (
    output i_start,
    output i_byte,
    output i_byte_valid,
    output i_addr_instr,
    input  o_instruction,
    input  o_cpu_valid,
    input  o_cpu_reset,
    input  o_loading,
    input  o_done,
    input  o_overflow,
    input  o_word_count
  );

endinterface
`default_nettype wire

// File: rtl/bip_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : bip_program_loader
// Description : Instruction memory owner for the BIP CPU. Loads a program
//               from a byte stream (high byte first) while holding the CPU
//               in reset, then releases the CPU and serves instruction
//               fetches combinationally so PC and instruction stay aligned
//               in the same cycle.
// Ports       : i_clock  - system clock, rising edge
//               i_reset  - asynchronous active-low reset
//               bus      - bip_program_loader_if.slave:
//                            i_start/i_byte/i_byte_valid  load stream
//                            i_addr_instr/o_instruction   fetch path
//                            o_cpu_valid/o_cpu_reset      CPU control
//                            o_loading/o_done/o_overflow/
//                            o_word_count                 load status
// Revision    : 1.0 - initial release
// ============================================================================
module bip_program_loader #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_BYTE            = 8,
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11
) (
  input  wire logic             i_clock,
  input  wire logic             i_reset,
  bip_program_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_HI = 2'd1,
    ST_LOAD_LO = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR =
    LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1);
  localparam logic [LOG2_N_INSMEM_ADDR-1:0] PTR_ONE = LOG2_N_INSMEM_ADDR'(1);
  localparam logic [LOG2_N_INSMEM_ADDR:0]   CNT_ONE = (LOG2_N_INSMEM_ADDR + 1)'(1);
  localparam logic [NB_OPCODE-1:0]          OPC_HALT = '0;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                        state_q, state_d;
  logic [NB_BYTE-1:0]            hi_q, hi_d;
  logic [LOG2_N_INSMEM_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_N_INSMEM_ADDR:0]   word_count_q, word_count_d;
  logic                          overflow_q, overflow_d;

  // Instruction memory; deliberately not reset so a reset never costs the
  // program image.
  logic [NB_DATA-1:0]            mem [N_INSMEM_ADDR];

  logic                          mem_we;
  logic [NB_DATA-1:0]            wr_word;
  logic                          wr_is_halt;
  logic                          wr_at_end;

  // The word being completed is the latched high byte plus the current byte.
  assign wr_word    = NB_DATA'({hi_q, bus.i_byte});
  assign wr_is_halt = (wr_word[NB_DATA-1 -: NB_OPCODE] == OPC_HALT);
  assign wr_at_end  = (wr_ptr_q == LAST_ADDR);

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;

    if (bus.i_start) begin
      // A start pulse always (re)begins a load from address 0; any byte
      // presented in the same cycle and any half-built word are dropped.
      state_d      = ST_LOAD_HI;
      hi_d         = '0;
      wr_ptr_d     = '0;
      word_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_LOAD_HI: begin
          if (bus.i_byte_valid) begin
            hi_d    = bus.i_byte;
            state_d = ST_LOAD_LO;
          end
        end

        ST_LOAD_LO: begin
          if (bus.i_byte_valid) begin
            mem_we       = 1'b1;
            word_count_d = word_count_q + CNT_ONE;
            // The pointer saturates at the last word instead of wrapping so
            // it never aliases back onto address 0.
            wr_ptr_d     = wr_at_end ? wr_ptr_q : (wr_ptr_q + PTR_ONE);
            if (wr_is_halt) begin
              state_d = ST_RUN;
            end else if (wr_at_end) begin
              state_d    = ST_RUN;
              overflow_d = 1'b1;
            end else begin
              state_d = ST_LOAD_HI;
            end
          end
        end

        ST_RUN: begin
          state_d = ST_RUN;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Everything is a function of the state register so the
  // asynchronous reset reaches the outputs without waiting for a clock.
  // --------------------------------------------------------------------------
  logic run;

  assign run = (state_q == ST_RUN);

  always_comb begin
    bus.o_cpu_valid  = run;
    bus.o_cpu_reset  = !run;
    bus.o_done       = run;
    bus.o_loading    = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);
    bus.o_overflow   = overflow_q;
    bus.o_word_count = word_count_q;
  end

  // Zero-latency fetch; outside RUN the CPU sees HALT so a partial or
  // in-progress program can never execute.
  always_comb begin
    bus.o_instruction = '0;
    if (run) begin
      bus.o_instruction = mem[bus.i_addr_instr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bip_program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bip_program_loader
// Description : Self-checking bench for bip_program_loader. A byte-list
//               reference model predicts memory contents and status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_program_loader;

  localparam int N = 2048;
  // {cpu_valid, cpu_reset, loading, done, overflow, word_count}
  localparam logic [16:0] RST_STATUS = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bip_program_loader_if bus ();

  bip_program_loader dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [15:0] m_mem     [N];
  bit          m_written [N];
  bit          m_loading, m_running, m_ovf;
  int          m_count;
  logic [7:0]  m_bytes [$];

  task automatic model_reset();
    m_loading = 0; m_running = 0; m_ovf = 0; m_count = 0; m_bytes.delete();
  endtask

  task automatic model_start();
    m_loading = 1; m_running = 0; m_ovf = 0; m_count = 0; m_bytes.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [15:0] w;
    if (!m_loading) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 2) begin
      w = {m_bytes[0], m_bytes[1]};
      m_bytes.delete();
      m_mem[m_count] = w;
      m_written[m_count] = 1;
      m_count++;
      if (w[15:11] == 5'd0) begin
        m_loading = 0; m_running = 1;
      end else if (m_count == N) begin
        m_loading = 0; m_running = 1; m_ovf = 1;
      end
    end
  endtask

  function automatic logic [16:0] exp_status();
    return {m_running, !m_running, m_loading, m_running, m_ovf, 12'(m_count)};
  endfunction

  function automatic logic [16:0] status();
    return {bus.o_cpu_valid, bus.o_cpu_reset, bus.o_loading, bus.o_done,
            bus.o_overflow, bus.o_word_count};
  endfunction

  // ---------------- stimulus primitives ----------------
  // Entered and left on a falling edge; inputs are held for one rising edge.
  task automatic cyc(input bit start, input bit valid, input logic [7:0] b);
    bus.i_start = start; bus.i_byte_valid = valid; bus.i_byte = b;
    if (start) model_start();
    else if (valid) model_byte(b);
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    repeat (gap) cyc(0, 0, 8'($urandom));
    cyc(0, 1, w[15:8]);
    repeat (gap) cyc(0, 0, 8'($urandom));
    cyc(0, 1, w[7:0]);
  endtask

  function automatic logic [15:0] rand_nonhalt();
    return {8'($urandom_range(8, 255)), 8'($urandom)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    checks++;
    if (status() !== RST_STATUS) begin
      errors++; $display("FAIL reset_status: got %h expected %h", status(), RST_STATUS);
    end
    bus.i_addr_instr = 11'($urandom); #1;
    checks++;
    if (bus.o_instruction !== 16'h0000) begin
      errors++; $display("FAIL reset_instr: got %h expected 0000", bus.o_instruction);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    cyc(1, 0, 8'h00);
    checks++;
    if (bus.o_loading !== 1'b1 || bus.o_cpu_reset !== 1'b1) begin
      errors++; $display("FAIL basic_loading: got loading=%b cpu_reset=%b expected 1 1",
                         bus.o_loading, bus.o_cpu_reset);
    end
    cyc(0, 1, 8'h18); cyc(0, 1, 8'h05); cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd2} || status() !== exp_status()) begin
      errors++; $display("FAIL basic_status: got %h expected %h", status(), exp_status());
    end
    bus.i_addr_instr = 11'd0; #1;
    checks++;
    if (bus.o_instruction !== 16'h1805) begin
      errors++; $display("FAIL basic_mem0: got %h expected 1805", bus.o_instruction);
    end
    bus.i_addr_instr = 11'd1; #1;
    checks++;
    if (bus.o_instruction !== 16'h0000) begin
      errors++; $display("FAIL basic_mem1: got %h expected 0000", bus.o_instruction);
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic [15:0] prog [5];
    logic [15:0] ref_words [5];
    int ref_cnt;
    for (int i = 0; i < 4; i++) prog[i] = rand_nonhalt();
    prog[4] = {5'd0, 11'($urandom)};
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) send_word(prog[i], 0);
    ref_cnt = int'(bus.o_word_count);
    bus.i_addr_instr = 11'd0;
    for (int i = 0; i < 5; i++) begin
      bus.i_addr_instr = 11'(i); #1; ref_words[i] = bus.o_instruction;
    end
    @(negedge clk);
    checks++;
    if (ref_cnt != 5) begin
      errors++; $display("FAIL gaps_b2b_count: got %0d expected 5", ref_cnt);
    end
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cyc(0, 1, prog[i][15:8]);
        repeat (3) cyc(0, 0, 8'($urandom));
        checks++;
        if (status() !== exp_status() || bus.o_loading !== 1'b1) begin
          errors++; $display("FAIL gaps_hold: got %h expected %h", status(), exp_status());
        end
        repeat (3) cyc(0, 0, 8'($urandom));
        cyc(0, 1, prog[i][7:0]);
      end else begin
        send_word(prog[i], 3);
      end
    end
    checks++;
    if (status() !== exp_status() || int'(bus.o_word_count) != ref_cnt) begin
      errors++; $display("FAIL gaps_status: got %h expected %h", status(), exp_status());
    end
    for (int i = 0; i < 5; i++) begin
      bus.i_addr_instr = 11'(i); #1;
      checks++;
      if (bus.o_instruction !== prog[i] || bus.o_instruction !== ref_words[i]) begin
        errors++; $display("FAIL gaps_mem[%0d]: got %h expected %h", i, bus.o_instruction, prog[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [15:0] w0;
    cyc(1, 0, 8'h00);
    for (int i = 0; i < N; i++) send_word(rand_nonhalt(), 0);
    w0 = m_mem[0];
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd2048} || status() !== exp_status()) begin
      errors++; $display("FAIL ovf_status: got %h expected %h", status(), exp_status());
    end
    cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
    checks++;
    if (status() !== exp_status()) begin
      errors++; $display("FAIL ovf_extra_status: got %h expected %h", status(), exp_status());
    end
    bus.i_addr_instr = 11'd0; #1;
    checks++;
    if (bus.o_instruction !== w0) begin
      errors++; $display("FAIL ovf_mem0: got %h expected %h", bus.o_instruction, w0);
    end
    for (int a = 0; a < N; a++) begin
      bus.i_addr_instr = 11'(a); #1;
      checks++;
      if (bus.o_instruction !== m_mem[a]) begin
        errors++; $display("FAIL ovf_mem[%0d]: got %h expected %h", a, bus.o_instruction, m_mem[a]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_restart_partial();
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h10);
    cyc(1, 1, 8'h77);
    cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1} || status() !== exp_status()) begin
      errors++; $display("FAIL restart_status: got %h expected %h", status(), exp_status());
    end
    bus.i_addr_instr = 11'd0; #1;
    checks++;
    if (bus.o_instruction !== 16'h0000) begin
      errors++; $display("FAIL restart_mem0: got %h expected 0000", bus.o_instruction);
    end
    @(negedge clk);
  endtask

  task automatic test_run_restart();
    cyc(1, 0, 8'h00);
    checks++;
    if (status() !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0} || status() !== exp_status()) begin
      errors++; $display("FAIL runrst_status: got %h expected %h", status(), exp_status());
    end
    for (int i = 0; i < 4; i++) begin
      bus.i_addr_instr = (i == 0) ? 11'd0 : 11'($urandom); #1;
      checks++;
      if (bus.o_instruction !== 16'h0000) begin
        errors++; $display("FAIL runrst_instr: got %h expected 0000", bus.o_instruction);
      end
    end
    @(negedge clk);
    send_word(16'h0000, 0);
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 8'h00);
    send_word(16'hA123, 0);
    cyc(0, 1, 8'h44);
    checks++;
    if (status() !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1}) begin
      errors++; $display("FAIL async_pre: got %h expected %h", status(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1});
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (status() !== RST_STATUS) begin
      errors++; $display("FAIL async_status: got %h expected %h", status(), RST_STATUS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
    checks++;
    if (status() !== RST_STATUS || status() !== exp_status()) begin
      errors++; $display("FAIL async_ignore: got %h expected %h", status(), RST_STATUS);
    end
    bus.i_addr_instr = 11'd0; #1;
    checks++;
    if (bus.o_instruction !== 16'h0000) begin
      errors++; $display("FAIL async_instr: got %h expected 0000", bus.o_instruction);
    end
    @(negedge clk);
  endtask

  task automatic test_random_programs();
    int len;
    for (int r = 0; r < 6; r++) begin
      cyc(1, $urandom_range(0, 1), 8'($urandom));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) send_word(rand_nonhalt(), $urandom_range(0, 2));
      send_word({5'd0, 11'($urandom)}, $urandom_range(0, 2));
      checks++;
      if (status() !== exp_status()) begin
        errors++; $display("FAIL rand%0d_status: got %h expected %h", r, status(), exp_status());
      end
      for (int a = 0; a < m_count; a++) begin
        bus.i_addr_instr = 11'(a); #1;
        checks++;
        if (bus.o_instruction !== m_mem[a]) begin
          errors++; $display("FAIL rand%0d_mem[%0d]: got %h expected %h", r, a, bus.o_instruction, m_mem[a]);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < N; a++) m_written[a] = 0;
    bus.i_start = 1'b0; bus.i_byte_valid = 1'b0; bus.i_byte = 8'h00;
    bus.i_addr_instr = 11'd0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_basic_load();
    test_gaps();
    test_overflow();
    test_restart_partial();
    test_run_restart();
    test_async_reset();
    test_random_programs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
